// File: rtl/rv32i_decode_execute.sv
// RV32I decode-to-execute slice: control decode, D/E register,
// operand muxes, ALU, and branch/jump resolution.
module rv32i_decode_execute #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            flush_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_ext_i,
    output logic [2:0]      imm_src_o,
    output logic [XLEN-1:0] alu_result_o,
    output logic            zero_o,
    output logic [XLEN-1:0] write_data_o,
    output logic [XLEN-1:0] pc_target_o,
    output logic            pcsrc_o,
    output logic            reg_write_o,
    output logic            mem_write_o,
    output logic [1:0]      result_src_o
);

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLL   = 4'b0101;
    localparam logic [3:0] ALU_SRL   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;
    localparam logic [3:0] ALU_SEQ   = 4'b1011;
    localparam logic [3:0] ALU_SGE   = 4'b1100;
    localparam logic [3:0] ALU_SGEU  = 4'b1101;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic [3:0]      alu_ctrl;
        logic            alu_src;
        logic            a_pc;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      result_src;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
    } de_t;

    de_t        de_d;
    de_t        de_q;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [3:0] arith_op;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];

    // Shared R/I arithmetic decode; SUB only exists for R-type.
    always_comb begin
        arith_op = ALU_ADD;
        case (funct3)
            3'b000: arith_op = (opcode == OP_R && instr_i[30]) ? ALU_SUB : ALU_ADD;
            3'b001: arith_op = ALU_SLL;
            3'b010: arith_op = ALU_SLT;
            3'b011: arith_op = ALU_SLTU;
            3'b100: arith_op = ALU_XOR;
            3'b101: arith_op = instr_i[30] ? ALU_SRA : ALU_SRL;
            3'b110: arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        de_d        = '0;
        de_d.pc     = pc_i;
        de_d.rs1    = rs1_data_i;
        de_d.rs2    = rs2_data_i;
        de_d.imm    = imm_ext_i;
        imm_src_o   = 3'b000;
        unique case (1'b1)
            opcode == OP_R: begin
                de_d.alu_ctrl  = arith_op;
                de_d.reg_write = 1'b1;
            end
            opcode == OP_I: begin
                de_d.alu_ctrl  = arith_op;
                de_d.alu_src   = 1'b1;
                de_d.reg_write = 1'b1;
            end
            opcode == OP_LOAD: begin
                de_d.alu_src    = 1'b1;
                de_d.result_src = 2'b01;
                de_d.reg_write  = 1'b1;
            end
            opcode == OP_STORE: begin
                de_d.alu_src   = 1'b1;
                de_d.mem_write = 1'b1;
                imm_src_o      = 3'b001;
            end
            opcode == OP_BRANCH: begin
                // Each op is chosen so a taken branch yields zero.
                de_d.branch = 1'b1;
                imm_src_o   = 3'b010;
                case (funct3)
                    3'b000:  de_d.alu_ctrl = ALU_SUB;
                    3'b001:  de_d.alu_ctrl = ALU_SEQ;
                    3'b100:  de_d.alu_ctrl = ALU_SGE;
                    3'b101:  de_d.alu_ctrl = ALU_SLT;
                    3'b110:  de_d.alu_ctrl = ALU_SGEU;
                    3'b111:  de_d.alu_ctrl = ALU_SLTU;
                    default: de_d.alu_ctrl = ALU_ADD;
                endcase
            end
            opcode == OP_JAL: begin
                de_d.jump       = 1'b1;
                de_d.result_src = 2'b10;
                de_d.reg_write  = 1'b1;
                imm_src_o       = 3'b011;
            end
            opcode == OP_JALR: begin
                de_d.jump       = 1'b1;
                de_d.jalr       = 1'b1;
                de_d.alu_src    = 1'b1;
                de_d.result_src = 2'b10;
                de_d.reg_write  = 1'b1;
            end
            opcode == OP_LUI: begin
                de_d.alu_ctrl  = ALU_PASSB;
                de_d.alu_src   = 1'b1;
                de_d.reg_write = 1'b1;
                imm_src_o      = 3'b100;
            end
            opcode == OP_AUIPC: begin
                de_d.a_pc      = 1'b1;
                de_d.alu_src   = 1'b1;
                de_d.reg_write = 1'b1;
                imm_src_o      = 3'b100;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            de_q <= '0;
        end else if (flush_i) begin
            de_q <= '0;
        end else begin
            de_q <= de_d;
        end
    end

    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_res;

    assign src_a = de_q.a_pc ? de_q.pc : de_q.rs1;
    assign src_b = de_q.alu_src ? de_q.imm : de_q.rs2;

    always_comb begin
        alu_res = src_a + src_b;
        case (de_q.alu_ctrl)
            ALU_SUB:   alu_res = src_a - src_b;
            ALU_AND:   alu_res = src_a & src_b;
            ALU_OR:    alu_res = src_a | src_b;
            ALU_XOR:   alu_res = src_a ^ src_b;
            ALU_SLL:   alu_res = src_a << src_b[4:0];
            ALU_SRL:   alu_res = src_a >> src_b[4:0];
            ALU_SRA:   alu_res = $unsigned($signed(src_a) >>> src_b[4:0]);
            ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
            ALU_PASSB: alu_res = src_b;
            ALU_SEQ:   alu_res = {{(XLEN-1){1'b0}}, src_a == src_b};
            ALU_SGE:   alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) >= $signed(src_b)};
            ALU_SGEU:  alu_res = {{(XLEN-1){1'b0}}, src_a >= src_b};
            default:   alu_res = src_a + src_b;
        endcase
    end

    assign alu_result_o = alu_res;
    assign zero_o       = (alu_res == '0);
    assign write_data_o = de_q.rs2;
    assign pc_target_o  = de_q.jalr ? {alu_res[XLEN-1:1], 1'b0}
                                    : de_q.pc + de_q.imm;
    assign pcsrc_o      = (de_q.branch & zero_o) | de_q.jump;
    assign reg_write_o  = de_q.reg_write;
    assign mem_write_o  = de_q.mem_write;
    assign result_src_o = de_q.result_src;

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Randomized + directed checks of rv32i_decode_execute against an
// instruction-semantics model.
module tb_rv32i_decode_execute;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [31:0] imm_ext_i = '0;
    logic [2:0]  imm_src_o;
    logic [31:0] alu_result_o;
    logic        zero_o;
    logic [31:0] write_data_o;
    logic [31:0] pc_target_o;
    logic        pcsrc_o;
    logic        reg_write_o;
    logic        mem_write_o;
    logic [1:0]  result_src_o;

    int vectors = 0;
    int miscompares = 0;

    rv32i_decode_execute #(.XLEN(32)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
        .instr_i(instr_i), .pc_i(pc_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .imm_ext_i(imm_ext_i), .imm_src_o(imm_src_o),
        .alu_result_o(alu_result_o), .zero_o(zero_o),
        .write_data_o(write_data_o), .pc_target_o(pc_target_o),
        .pcsrc_o(pcsrc_o), .reg_write_o(reg_write_o),
        .mem_write_o(mem_write_o), .result_src_o(result_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] alu;
        logic        zero;
        logic [31:0] wd;
        logic [31:0] tgt;
        logic        pcsrc;
        logic        rw;
        logic        mw;
        logic [1:0]  rs;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] arith(input logic [2:0] f3,
                                          input logic alt,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        case (f3)
            3'd0: return alt ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [2:0] imm_type(input logic [31:0] ins);
        case (ins[6:0])
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b1101111: return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins,
                                   input logic [31:0] pc,
                                   input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic [31:0] imm);
        exp_t e;
        logic [2:0] f3;
        logic taken;
        f3 = ins[14:12];
        taken = 1'b0;
        e.alu = a + b;
        e.wd = b;
        e.tgt = pc + imm;
        e.pcsrc = 1'b0;
        e.rw = 1'b0;
        e.mw = 1'b0;
        e.rs = 2'b00;
        case (ins[6:0])
            7'b0110011: begin
                e.alu = arith(f3, ins[30], a, b);
                e.rw = 1'b1;
            end
            7'b0010011: begin
                e.alu = arith(f3, (f3 == 3'd5) && ins[30], a, imm);
                e.rw = 1'b1;
            end
            7'b0000011: begin
                e.alu = a + imm; e.rw = 1'b1; e.rs = 2'b01;
            end
            7'b0100011: begin
                e.alu = a + imm; e.mw = 1'b1;
            end
            7'b1100011: begin
                case (f3)
                    3'd0: begin e.alu = a - b; taken = (a == b); end
                    3'd1: begin e.alu = {31'd0, a == b}; taken = (a != b); end
                    3'd4: begin
                        e.alu = {31'd0, $signed(a) >= $signed(b)};
                        taken = $signed(a) < $signed(b);
                    end
                    3'd5: begin
                        e.alu = {31'd0, $signed(a) < $signed(b)};
                        taken = $signed(a) >= $signed(b);
                    end
                    3'd6: begin e.alu = {31'd0, a >= b}; taken = (a < b); end
                    default: begin e.alu = {31'd0, a < b}; taken = (a >= b); end
                endcase
                e.pcsrc = taken;
            end
            7'b1101111: begin
                e.pcsrc = 1'b1; e.rw = 1'b1; e.rs = 2'b10;
            end
            7'b1100111: begin
                e.alu = a + imm;
                e.tgt = (a + imm) & 32'hFFFF_FFFE;
                e.pcsrc = 1'b1; e.rw = 1'b1; e.rs = 2'b10;
            end
            7'b0110111: begin e.alu = imm; e.rw = 1'b1; end
            7'b0010111: begin e.alu = pc + imm; e.rw = 1'b1; end
            default: ;
        endcase
        e.zero = (e.alu == 32'd0);
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.alu = '0; e.zero = 1'b1; e.wd = '0; e.tgt = '0;
        e.pcsrc = 1'b0; e.rw = 1'b0; e.mw = 1'b0; e.rs = 2'b00;
        return e;
    endfunction

    // Drive at negedge, load at posedge, compare at next negedge.
    task automatic step(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm, input logic fl);
        exp_t e;
        instr_i = ins; pc_i = pc; rs1_data_i = a;
        rs2_data_i = b; imm_ext_i = imm; flush_i = fl;
        #1;
        chk("imm_src", {29'd0, imm_src_o}, {29'd0, imm_type(ins)});
        e = fl ? bubble() : model(ins, pc, a, b, imm);
        @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b0;
        chk("alu_result", alu_result_o, e.alu);
        chk("zero", {31'd0, zero_o}, {31'd0, e.zero});
        chk("write_data", write_data_o, e.wd);
        chk("pc_target", pc_target_o, e.tgt);
        chk("pcsrc", {31'd0, pcsrc_o}, {31'd0, e.pcsrc});
        chk("reg_write", {31'd0, reg_write_o}, {31'd0, e.rw});
        chk("mem_write", {31'd0, mem_write_o}, {31'd0, e.mw});
        chk("result_src", {30'd0, result_src_o}, {30'd0, e.rs});
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3,
                                       input logic [6:0] f7);
        return {f7, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011,
                             7'b0100011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111,
                             7'b0001111, 7'b1110011};
    logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    initial begin
        logic [31:0] ins, a, b;
        repeat (2) @(negedge clk_i);
        chk("rst_alu", alu_result_o, 32'd0);
        chk("rst_zero", {31'd0, zero_o}, 32'd1);
        chk("rst_pcsrc", {31'd0, pcsrc_o}, 32'd0);
        rstn_i = 1'b1;

        step(mk(7'b0110011, 3'd0, 7'd0), 32'h0, 32'd5, 32'd7, 32'd0, 1'b0);
        chk("add", alu_result_o, 32'd12);
        rstn_i = 1'b0;
        #1;
        chk("async_rst_alu", alu_result_o, 32'd0);
        chk("async_rst_rw", {31'd0, reg_write_o}, 32'd0);
        chk("async_rst_pcsrc", {31'd0, pcsrc_o}, 32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        step(mk(7'b0110011, 3'd0, 7'h20), 32'h0, 32'd3, 32'd5, 32'd0, 1'b0);
        chk("sub", alu_result_o, 32'hFFFF_FFFE);
        step(mk(7'b0110011, 3'd5, 7'h20), 32'h0, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
        chk("sra", alu_result_o, 32'hF800_0000);
        step(mk(7'b0110011, 3'd3, 7'd0), 32'h0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        chk("sltu", alu_result_o, 32'd1);
        step(mk(7'b1100011, 3'd1, 7'd0), 32'h100, 32'd4, 32'd4, 32'h20, 1'b0);
        chk("bne_eq", {31'd0, pcsrc_o}, 32'd0);
        step(mk(7'b1100011, 3'd4, 7'd0), 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
        chk("blt_taken", {31'd0, pcsrc_o}, 32'd1);
        chk("blt_target", pc_target_o, 32'h120);
        step(mk(7'b1100011, 3'd7, 7'd0), 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20, 1'b0);
        chk("bgeu", {31'd0, pcsrc_o}, 32'd0);
        step(mk(7'b0110111, 3'd0, 7'd0), 32'h0, 32'h55, 32'h0, 32'h1234_5000, 1'b0);
        chk("lui", alu_result_o, 32'h1234_5000);
        chk("lui_rs", {30'd0, result_src_o}, 32'd0);
        step(mk(7'b0010111, 3'd0, 7'd0), 32'h40, 32'h99, 32'h0, 32'h1000, 1'b0);
        chk("auipc", alu_result_o, 32'h1040);
        step(mk(7'b1100111, 3'd0, 7'd0), 32'h0, 32'h203, 32'h0, 32'd4, 1'b0);
        chk("jalr_tgt", pc_target_o, 32'h206);
        chk("jalr_pcsrc", {31'd0, pcsrc_o}, 32'd1);
        chk("jalr_rs", {30'd0, result_src_o}, 32'd2);
        step(mk(7'b1101111, 3'd0, 7'd0), 32'h10, 32'h0, 32'h0, 32'hFFFF_FFF8, 1'b0);
        chk("jal_tgt", pc_target_o, 32'h8);
        step(mk(7'b0100011, 3'd2, 7'd0), 32'h0, 32'h100, 32'hAB, 32'd8, 1'b0);
        chk("sw_mw", {31'd0, mem_write_o}, 32'd1);
        chk("sw_addr", alu_result_o, 32'h108);
        chk("sw_data", write_data_o, 32'hAB);
        chk("sw_rw", {31'd0, reg_write_o}, 32'd0);
        step(mk(7'b0100011, 3'd2, 7'd0), 32'h0, 32'h100, 32'hAB, 32'd8, 1'b1);
        chk("flush_mw", {31'd0, mem_write_o}, 32'd0);

        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 10)];
            if (ins[6:0] == 7'b1100011)
                ins[14:12] = bf3[$urandom_range(0, 5)];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 40);
            step(ins, $urandom, a, b, $urandom, $urandom_range(0, 9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv32i_decode_execute.md
Name: rv32i_decode_execute

Overview:
- Decode-to-execute slice of the 5-stage RV32I pipeline.
- Combinational main/ALU control decode of the decode-stage instruction feeds a D/E pipeline register.
- The execute side holds the ALU-operand select muxes, the ALU with zero flag, branch/jump resolution and the branch-target adder.
- Upstream: register file and immediate extender. Downstream: the E/M register.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  asynchronous active-low reset
flush_i  in  1  synchronous clear of D/E register (bubble insert)
instr_i  in  32  decode-stage instruction
pc_i  in  32  decode-stage PC
rs1_data_i  in  32  forwarded rs1 operand (forwarding resolved upstream)
rs2_data_i  in  32  forwarded rs2 operand
imm_ext_i  in  32  extended immediate for instr_i
imm_src_o  out  3  combinational immediate type for instr_i: 000 I, 001 S, 010 B, 011 J, 100 U
alu_result_o  out  32  execute-stage ALU result
zero_o  out  1  alu_result_o == 0
write_data_o  out  32  registered rs2 operand (store data)
pc_target_o  out  32  branch/jump target
pcsrc_o  out  1  take target: (branch & zero_o) | jump
reg_write_o  out  1  execute-stage register write enable
mem_write_o  out  1  execute-stage memory write enable
result_src_o  out  2  00 ALU, 01 memory, 10 PC+4

Behaviour:
- Reset: when rstn_i is low, all D/E register bits clear to 0 asynchronously. A zeroed register is a bubble: all enables 0, ALU op ADD, operands 0, so alu_result_o=0, zero_o=1, pcsrc_o=0.
- flush_i=1 at a rising edge: loads the same all-zero bubble. Reset has priority over flush.
- Latency: instr_i decoded at edge N is presented on the execute outputs from N until edge N+1. All execute outputs are combinational from the register.
- ALU control codes (4 bit):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA.
  - 1000 SLT, 1001 SLTU.
  - 1010 PASSB.
  - 1011 SEQ, 1100 SGE (signed), 1101 SGEU.
  - 1110/1111 behave as ADD.
  - Shift amount is B[4:0]. Compare ops produce 0 or 1. ADD/SUB wrap modulo 2^32.
- Operand A: PC for AUIPC, else rs1. Operand B: imm_ext for ALUSrc=1, else rs2.
- Decode by opcode:
  - R-type (0110011): funct3/funct7[5] select op (SUB, SRA when funct7[5]=1); RegWrite.
  - I-ALU (0010011): same ops; SRAI when instr[30]=1; ADDI never SUB; ALUSrc; RegWrite.
  - Load (0000011): ADD, ALUSrc, ResultSrc 01, RegWrite.
  - Store (0100011): ADD, ALUSrc, MemWrite, ImmSrc S.
  - Branch (1100011): Branch, ImmSrc B. ALU op by funct3: BEQ→SUB, BNE→SEQ, BLT→SGE, BGE→SLT, BLTU→SGEU, BGEU→SLTU. The branch is taken when the result is zero.
  - JAL (1101111): Jump, ResultSrc 10, RegWrite, ImmSrc J.
  - JALR (1100111): Jump, ADD, ALUSrc, ResultSrc 10, RegWrite, ImmSrc I.
  - LUI (0110111): PASSB, ALUSrc, RegWrite, ImmSrc U.
  - AUIPC (0010111): ADD, A=PC, ALUSrc, RegWrite, ImmSrc U.
  - Any other opcode, including SYSTEM/FENCE: all enables 0, ALU ADD.
- pc_target_o:
  - JALR: {alu_result_o[31:1],1'b0}.
  - Otherwise: registered PC + registered imm, modulo 2^32.
- rd==x0 is not filtered here; the register file ignores x0 writes.

Test Plan:
1. Reset mid-operation: load ADD x3,x1,x2 with rs1=5, rs2=7, pull rstn_i low → immediately alu_result_o=0, reg_write_o=0, pcsrc_o=0.
2. R-type: SUB with rs1=3, rs2=5 → alu_result_o=0xFFFFFFFE. SRA 0x80000000>>4 → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1.
3. Branches, pc=0x100, imm=0x20:
   - BNE 4,4 → pcsrc_o=0.
   - BLT -1,1 → pcsrc_o=1, pc_target_o=0x120.
   - BGEU 1,0xFFFFFFFF → pcsrc_o=0.
4. LUI with imm=0x12345000 → alu_result_o=0x12345000. AUIPC at pc=0x40, imm=0x1000 → 0x1040. Both give result_src_o=00.
5. Jumps:
   - JALR with rs1=0x203, imm=4 → pc_target_o=0x206, pcsrc_o=1, result_src_o=10.
   - JAL at pc=0x10, imm=-8 → pc_target_o=0x8.
6. Store SW, rs1=0x100, imm=8, rs2=0xAB → mem_write_o=1, alu_result_o=0x108, write_data_o=0xAB, reg_write_o=0. Next edge with flush_i=1 → all enables 0.
